// File: rtl/sw_debounce_pkg.sv
// Shared constants for the switch debouncer: FSM state encoding and synchroniser depth.
package sw_debounce_pkg;

    localparam int SYNC_DEPTH = 2;

    localparam logic [1:0] ENC_LOW       = 2'd0;
    localparam logic [1:0] ENC_RISE_WAIT = 2'd1;
    localparam logic [1:0] ENC_HIGH      = 2'd2;
    localparam logic [1:0] ENC_FALL_WAIT = 2'd3;

    typedef enum logic [1:0] {
        S_LOW       = ENC_LOW,
        S_RISE_WAIT = ENC_RISE_WAIT,
        S_HIGH      = ENC_HIGH,
        S_FALL_WAIT = ENC_FALL_WAIT
    } db_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop synchroniser, stability counter, level/strobe FSM.
// Optional auto-repeat of the rise strobe under SW_DEBOUNCE_AUTOREPEAT_EN.
//
// state        | meaning
// S_LOW        | accepted level 0, input agrees
// S_RISE_WAIT  | accepted level 0, input has been 1 for cnt_q cycles
// S_HIGH       | accepted level 1, input agrees
// S_FALL_WAIT  | accepted level 1, input has been 0 for cnt_q cycles
module debounce_channel
    import sw_debounce_pkg::*;
#(
    parameter int NB_DB          = 20,
    parameter int DEBOUNCE_TICKS = 1000000,
    parameter int REPEAT_DELAY   = 50000000,
    parameter int REPEAT_TICKS   = 10000000
) (
    input  logic clock,
    input  logic i_reset,
    input  logic sw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic rise_nxt
);

    localparam logic [NB_DB-1:0] CNT_TC  = NB_DB'(DEBOUNCE_TICKS);
    localparam logic [NB_DB-1:0] CNT_ONE = NB_DB'(1);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  sw_s;
    db_state_t             state_q, state_d;
    logic [NB_DB-1:0]      cnt_q, cnt_d;
    logic                  level_d, rise_d, fall_d;

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], sw};
        end
    end

    assign sw_s = sync_q[SYNC_DEPTH-1];

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
            level   <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level   <= level_d;
            rise    <= rise_nxt;
            fall    <= fall_d;
        end
    end

    // The counter is cleared on acceptance and on abandon, so it never passes CNT_TC.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            S_LOW: begin
                if (sw_s) begin
                    state_d = S_RISE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            S_RISE_WAIT: begin
                if (!sw_s) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_TC) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!sw_s) begin
                    state_d = S_FALL_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            S_FALL_WAIT: begin
                if (sw_s) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_TC) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

`ifdef SW_DEBOUNCE_AUTOREPEAT_EN
    localparam int NB_RPT = $clog2(max_int(REPEAT_DELAY, REPEAT_TICKS) + 1);
    localparam logic [NB_RPT-1:0] RPT_DELAY_LD = NB_RPT'(REPEAT_DELAY - 1);
    localparam logic [NB_RPT-1:0] RPT_TICKS_LD = NB_RPT'(REPEAT_TICKS - 1);

    logic [NB_RPT-1:0] rpt_q, rpt_d;
    logic              rpt_fire;

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end

    // Down-counter reloaded on every entry into S_HIGH, fires at terminal count.
    always_comb begin
        rpt_d    = '0;
        rpt_fire = 1'b0;
        if (state_q != S_HIGH && state_d == S_HIGH) begin
            rpt_d = RPT_DELAY_LD;
        end else if (state_q == S_HIGH && state_d == S_HIGH) begin
            if (rpt_q == '0) begin
                rpt_fire = 1'b1;
                rpt_d    = RPT_TICKS_LD;
            end else begin
                rpt_d = rpt_q - 1'b1;
            end
        end
    end

    assign rise_nxt = rise_d | rpt_fire;
`else
    logic unused_rpt_cfg;
    assign unused_rpt_cfg = ^{REPEAT_DELAY, REPEAT_TICKS};
    assign rise_nxt       = rise_d;
`endif

endmodule

// File: rtl/sw_debounce.sv
// Multi-channel switch debouncer; per-channel logic in debounce_channel, o_valid flags any rise.
// Build option SW_DEBOUNCE_AUTOREPEAT_EN adds auto-repeat rise strobes while a channel is held.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int NB_SW          = 4,
    parameter int NB_DB          = 20,
    parameter int DEBOUNCE_TICKS = 1000000,
    parameter int REPEAT_DELAY   = 50000000,
    parameter int REPEAT_TICKS   = 10000000
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic [NB_SW-1:0] i_sw,
    output logic [NB_SW-1:0] o_level,
    output logic [NB_SW-1:0] o_rise,
    output logic [NB_SW-1:0] o_fall,
    output logic             o_valid
);

    logic [NB_SW-1:0] rise_nxt;

    for (genvar g = 0; g < NB_SW; g++) begin : g_ch
        debounce_channel #(
            .NB_DB         (NB_DB),
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_TICKS  (REPEAT_TICKS)
        ) u_ch (
            .clock   (clock),
            .i_reset (i_reset),
            .sw      (i_sw[g]),
            .level   (o_level[g]),
            .rise    (o_rise[g]),
            .fall    (o_fall[g]),
            .rise_nxt(rise_nxt[g])
        );
    end

    // Built from the channels' next-cycle rise so o_valid lines up with o_rise.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            o_valid <= 1'b0;
        end else begin
            o_valid <= |rise_nxt;
        end
    end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with DEBOUNCE_TICKS=4, REPEAT_DELAY=10, REPEAT_TICKS=3.
module tb_sw_debounce;

    logic       clock = 1'b0;
    logic       i_reset;
    logic [3:0] i_sw;
    logic [3:0] o_level, o_rise, o_fall;
    logic       o_valid;

    sw_debounce #(
        .NB_SW         (4),
        .NB_DB         (20),
        .DEBOUNCE_TICKS(4),
        .REPEAT_DELAY  (10),
        .REPEAT_TICKS  (3)
    ) dut (
        .clock  (clock),
        .i_reset(i_reset),
        .i_sw   (i_sw),
        .o_level(o_level),
        .o_rise (o_rise),
        .o_fall (o_fall),
        .o_valid(o_valid)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          cyc;
        string       tag;
        logic [12:0] exp;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [12:0] obs_now();
        return {o_level, o_rise, o_fall, o_valid};
    endfunction

    task automatic push(input int c, input string tag, input logic [3:0] lv,
                        input logic [3:0] rs, input logic [3:0] fl, input logic v);
        exp_t e;
        e.cyc = c;
        e.tag = tag;
        e.exp = {lv, rs, fl, v};
        sb.push_back(e);
    endtask

    task automatic push_range(input int c0, input int c1, input string tag,
                              input logic [3:0] lv);
        for (int c = c0; c <= c1; c++) push(c, tag, lv, 4'b0, 4'b0, 1'b0);
    endtask

    task automatic tick();
        exp_t        e;
        logic [12:0] obs;
        @(posedge clock);
        #1;
        cyc++;
        obs = obs_now();
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            assert (obs === e.exp && e.cyc == cyc) else begin
                errors++;
                $error("FAIL %s cyc=%0d observed=%h expected=%h", e.tag, cyc, obs, e.exp);
            end
        end
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    int         t;
    logic [7:0] bounce_pat;
    logic       rpt;

    initial begin
        i_reset = 1'b1;
        i_sw    = 4'b0;
        repeat (3) tick();
        checks++;
        assert (obs_now() === 13'h0) else begin
            errors++;
            $error("FAIL reset_state observed=%h expected=%h", obs_now(), 13'h0);
        end

        // clean press on ch0, released right after acceptance
        t = cyc;
        i_reset = 1'b0;
        i_sw    = 4'b0001;
        push_range(t + 1, t + 6, "press_wait", 4'b0000);
        push(t + 7, "press_acc", 4'b0001, 4'b0001, 4'b0000, 1'b1);
        run_to(t + 7);
        i_sw = 4'b0000;
        push_range(t + 8, t + 13, "rel_wait", 4'b0001);
        push(t + 14, "rel_acc", 4'b0000, 4'b0000, 4'b0001, 1'b0);
        push_range(t + 15, t + 17, "rel_idle", 4'b0000);
        run_to(t + 17);

        // bounce on ch1: 1,1,0,1,1,1,0 then held 1
        t = cyc;
        bounce_pat = 8'b1011_1011;
        push_range(t + 1, t + 13, "bounce_rej", 4'b0000);
        push(t + 14, "bounce_acc", 4'b0010, 4'b0010, 4'b0000, 1'b1);
        for (int i = 0; i < 8; i++) begin
            i_sw[1] = bounce_pat[i];
            tick();
        end
        run_to(t + 14);
        i_sw = 4'b0000;
        push_range(t + 15, t + 20, "bounce_rel_wait", 4'b0010);
        push(t + 21, "bounce_rel_acc", 4'b0000, 4'b0000, 4'b0010, 1'b0);
        push_range(t + 22, t + 23, "bounce_idle", 4'b0000);
        run_to(t + 23);

        // simultaneous press on ch1 and ch3
        t = cyc;
        i_sw = 4'b1010;
        push_range(t + 1, t + 6, "simul_wait", 4'b0000);
        push(t + 7, "simul_acc", 4'b1010, 4'b1010, 4'b0000, 1'b1);
        run_to(t + 7);
        i_sw = 4'b0000;
        push_range(t + 8, t + 13, "simul_rel_wait", 4'b1010);
        push(t + 14, "simul_rel_acc", 4'b0000, 4'b0000, 4'b1010, 1'b0);
        push(t + 15, "simul_idle", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        run_to(t + 15);

        // reset while ch0 is high and ch2 sits in S_RISE_WAIT with counter 2
        t = cyc;
        i_sw = 4'b0001;
        push_range(t + 1, t + 6, "rst_pre_wait", 4'b0000);
        push(t + 7, "rst_pre_acc", 4'b0001, 4'b0001, 4'b0000, 1'b1);
        run_to(t + 7);
        i_sw = 4'b0101;
        push_range(t + 8, t + 11, "rst_pre_hold", 4'b0001);
        run_to(t + 11);
        i_reset = 1'b1;
        #1;
        checks++;
        assert (obs_now() === 13'h0) else begin
            errors++;
            $error("FAIL reset_async observed=%h expected=%h", obs_now(), 13'h0);
        end
        push_range(t + 12, t + 13, "rst_held", 4'b0000);
        run_to(t + 13);
        i_reset = 1'b0;
        push_range(t + 14, t + 19, "rst_post_wait", 4'b0000);
        push(t + 20, "rst_post_acc", 4'b0101, 4'b0101, 4'b0000, 1'b1);
        run_to(t + 20);
        i_sw = 4'b0000;
        push_range(t + 21, t + 26, "rst_rel_wait", 4'b0101);
        push(t + 27, "rst_rel_acc", 4'b0000, 4'b0000, 4'b0101, 1'b0);
        push(t + 28, "rst_idle", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        run_to(t + 28);

        // long hold on ch2: repeat strobes 10 cycles after acceptance, then every 3
        t = cyc;
        i_sw = 4'b0100;
        push_range(t + 1, t + 6, "hold_wait", 4'b0000);
        push(t + 7, "hold_acc", 4'b0100, 4'b0100, 4'b0000, 1'b1);
        for (int c = t + 8; c <= t + 30; c++) begin
            rpt = 1'b0;
`ifdef SW_DEBOUNCE_AUTOREPEAT_EN
            rpt = (c >= t + 17) && (c <= t + 26) && (((c - t - 17) % 3) == 0);
`endif
            push(c, "hold_rpt", 4'b0100, rpt ? 4'b0100 : 4'b0000, 4'b0000, rpt);
        end
        run_to(t + 24);
        i_sw = 4'b0000;
        push(t + 31, "hold_rel_acc", 4'b0000, 4'b0000, 4'b0100, 1'b0);
        push(t + 32, "hold_idle", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        run_to(t + 33);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL drain observed=%0d expected=%0d", sb.size(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sw_debounce.md
# sw_debounce

Input-side conditioning block for the board's switches and push-buttons. It performs three steps per input:

- synchronises each raw `i_sw` bit into the `clock` domain;
- debounces it with a per-bit stability counter and state machine;
- reports the clean level plus single-cycle rise/fall strobes.

It sits between the board pins and the counter/shift-register LED logic, so downstream blocks consume clean `i_valid`-style pulses instead of raw, bouncing switch levels.

## Interface
- `NB_SW`, 4, number of independent input channels.
- `NB_DB`, 20, debounce counter width.
- `DEBOUNCE_TICKS`, 1000000, consecutive stable cycles required to accept a level change (10 ms at 100 MHz). Legal range is 1 to 2^NB_DB−1.
- `REPEAT_DELAY`, 50000000, cycles held high before the first auto-repeat strobe (auto-repeat build only).
- `REPEAT_TICKS`, 10000000, cycles between subsequent auto-repeat strobes (auto-repeat build only).
- `clock`, in, 1, single system clock; all logic is rising-edge.
- `i_reset`, in, 1, asynchronous, active-high reset.
- `i_sw`, in, NB_SW, raw asynchronous switch/button levels.
- `o_level`, out, NB_SW, debounced level per channel.
- `o_rise`, out, NB_SW, one-cycle strobe per channel when an accepted 0→1 occurs (plus repeat strobes if enabled).
- `o_fall`, out, NB_SW, one-cycle strobe per channel when an accepted 1→0 occurs.
- `o_valid`, out, 1, OR-reduction of `o_rise`, registered in the same cycle as `o_rise`.

## Operation
- Each channel has its own 2-flop synchroniser, counter and FSM; channels are fully independent.
- FSM states: `S_LOW`, `S_RISE_WAIT`, `S_HIGH`, `S_FALL_WAIT`.
- `S_LOW`:
  - synchronised input = 1 → go to `S_RISE_WAIT` and set the counter to 1;
  - otherwise stay.
- `S_RISE_WAIT`:
  - input = 0 → go back to `S_LOW`, clear the counter, emit no strobe;
  - input = 1 and counter = DEBOUNCE_TICKS → go to `S_HIGH`, set `o_level` = 1, pulse `o_rise` for one cycle;
  - otherwise increment the counter.
- `S_HIGH` and `S_FALL_WAIT` mirror `S_LOW` and `S_RISE_WAIT` with the polarity inverted; acceptance sets `o_level` = 0 and pulses `o_fall`.
- Glitch shorter than DEBOUNCE_TICKS: returns to the originating state, and the counter restarts from 1 on the next opposite sample. No output changes.
- Counter saturation: the counter never exceeds DEBOUNCE_TICKS, so it cannot wrap.
- Strobes are registered outputs. `o_rise` and `o_fall` are never high together on the same channel.
- Simultaneous acceptances on several channels in one cycle are all reported in that cycle; `o_valid` is then 1 for exactly that cycle.
- Reset, asynchronous at any time including mid-WAIT:
  - all FSMs go to `S_LOW`, counters and synchronisers go to 0;
  - `o_level`, `o_rise`, `o_fall` and `o_valid` go to 0.
- A switch held high through reset release is accepted DEBOUNCE_TICKS+3 cycles later and produces a normal `o_rise`.

## Timing
- Latency: `i_sw` stable from clock edge N gives `o_level`/`o_rise` asserted after edge N+DEBOUNCE_TICKS+3. This breaks down as:
  - 2 edges in the synchroniser;
  - 1 edge to enter WAIT;
  - DEBOUNCE_TICKS−1 edges counting;
  - 1 edge for the output register.
- Release latency is identical.
- Strobe width is exactly 1 cycle. The minimum spacing between `o_rise` and `o_fall` on one channel is DEBOUNCE_TICKS+1 cycles.
- No handshake: consumers must sample the strobes every cycle.

## Configuration
- Macro: `SW_DEBOUNCE_AUTOREPEAT_EN`.
- Defined:
  - while a channel stays in `S_HIGH`, a repeat counter re-pulses `o_rise` (and `o_valid`) REPEAT_DELAY cycles after acceptance, then every REPEAT_TICKS cycles;
  - leaving `S_HIGH` (entering `S_FALL_WAIT`) or reset clears the repeat counter;
  - returning from `S_FALL_WAIT` to `S_HIGH` after a glitch restarts the repeat delay from 0.
- Undefined:
  - no repeat counter is synthesised and the REPEAT parameters are ignored;
  - exactly one `o_rise` is produced per accepted press.

## Structure
- Package `sw_debounce_pkg`: FSM state encoding (2-bit localparams for `S_LOW`, `S_RISE_WAIT`, `S_HIGH`, `S_FALL_WAIT`) and the synchroniser depth constant (2).
- Sub-module `debounce_channel`:
  - contains one synchroniser, counter, FSM and optional repeat logic;
  - instantiated NB_SW times by a generate loop in `sw_debounce`;
  - `sw_debounce` adds only the `o_valid` OR-reduction register.

## Test plan
All scenarios use DEBOUNCE_TICKS=4, REPEAT_DELAY=10 and REPEAT_TICKS=3.

- Reset/clean press: deassert reset, `i_sw`=4'b0001 held from edge 0 → `o_level`[0]=1 and `o_rise`[0]=1 exactly at edge 7, `o_valid`=1 at edge 7 only; all other outputs stay 0.
- Bounce rejection: `i_sw`[1] toggled 1,1,0,1,1,1,0 per cycle → no `o_rise`; then held at 1 → `o_rise`[1] pulses 7 edges after the last 0→1.
- Release: channel 0 high and stable, then `i_sw`[0]=0 → `o_fall`[0] pulses once, 7 edges later, and `o_level`[0]=0 at the same edge.
- Simultaneous: `i_sw` goes 0→4'b1010 on one edge → `o_rise`=4'b1010 in one cycle, `o_valid`=1 for 1 cycle.
- Reset mid-operation: assert `i_reset` during `S_RISE_WAIT` (counter=2) → all outputs 0 immediately, with no strobe after release unless the input is re-held for the full 7 edges.
- Auto-repeat (macro defined): hold `i_sw`[2]=1 → `o_rise`[2] pulses at acceptance, then 10 cycles later, then every 3 cycles; without the macro → a single pulse only.
